// File: rtl/data_mem_lat.sv
// Byte-addressed data memory with valid/yumi handshake, N-cycle response latency
// and byte/half/word/dword access sizes. Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses.
module data_mem_lat #(
    parameter int addr_width_p = 12,
    parameter int data_width_p = 32,
    parameter int latency_p    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid_i,
    input  logic                    req_wen_i,
    input  logic [1:0]              req_size_i,
    input  logic [addr_width_p-1:0] req_addr_i,
    input  logic [data_width_p-1:0] req_wdata_i,
    output logic                    req_yumi_o,
    output logic                    resp_valid_o,
    output logic [data_width_p-1:0] resp_rdata_o,
    output logic                    resp_err_o,
    input  logic                    resp_yumi_i
);
    localparam int depth_lp = 2 ** addr_width_p;
    localparam int lanes_lp = data_width_p / 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [7:0]              mem [depth_lp];

    logic [3:0]              size_bytes;
    logic                    size_illegal;
    logic                    misaligned;
    logic                    acc_err;
    logic [addr_width_p-1:0] lane_addr [lanes_lp];
    logic [lanes_lp-1:0]     lane_en;
    logic [data_width_p-1:0] load_data;

    assign size_bytes   = 4'd1 << req_size_i;
    assign size_illegal = (req_size_i == 2'd3) && (data_width_p == 32);

`ifdef DMEM_ALIGN_CHECK_EN
    logic [2:0] align_mask;
    assign align_mask = 3'(size_bytes - 4'd1);
    assign misaligned = |(req_addr_i[2:0] & align_mask);
`else
    assign misaligned = 1'b0;
`endif

    assign acc_err    = size_illegal | misaligned;
    assign req_yumi_o = req_valid_i & reset & (state_r == IDLE);

    // Each lane addresses its own byte so accesses wrap at the top of memory.
    generate
        for (genvar gi = 0; gi < lanes_lp; gi++) begin : g_lane
            assign lane_addr[gi] = req_addr_i + addr_width_p'(gi);
            assign lane_en[gi]   = 4'(gi) < size_bytes;
            assign load_data[8*gi +: 8] = lane_en[gi] ? mem[lane_addr[gi]] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (req_yumi_o && req_wen_i && !acc_err) begin
            for (int k = 0; k < lanes_lp; k++) begin
                if (lane_en[k]) begin
                    mem[lane_addr[k]] <= req_wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_yumi_o) begin
                        resp_err_o   <= acc_err;
                        resp_rdata_o <= (req_wen_i || acc_err) ? '0 : load_data;
                        if (latency_p > 1) begin
                            state_r <= WAIT;
                            cnt_r   <= 4'(latency_p - 1);
                        end else begin
                            state_r      <= RESP;
                            resp_valid_o <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Leaving as the count reaches zero puts the response at accept + latency_p.
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r      <= RESP;
                        resp_valid_o <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_yumi_i) begin
                        state_r      <= IDLE;
                        resp_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    resp_valid_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/data_mem_lat.md
# data_mem_lat

Parametrised byte-addressed data memory for the core, with the valid/yumi request/response handshake, configurable response latency, data width and access size (byte/half/word/dword). It sits between the core's load/store stage and the memory model. It generalises the single-cycle byte/word memory to N-cycle latency and multiple access sizes, with optional alignment checking.

## Interface
- addr_width_p, 12, byte address width; depth = 2**addr_width_p bytes
- data_width_p, 32, port data width in bits; legal values 32 or 64
- latency_p, 1, cycles from request acceptance to response valid; legal range 1..15
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- req_valid_i  in  1  core request valid
- req_wen_i  in  1  1 = store, 0 = load
- req_size_i  in  2  log2 access bytes: 0 = byte, 1 = half, 2 = word, 3 = dword (3 legal only when data_width_p = 64)
- req_addr_i  in  addr_width_p  byte address of the lowest byte
- req_wdata_i  in  data_width_p  store data, little-endian, low bytes used
- req_yumi_o  out  1  request accepted this cycle (combinational)
- resp_valid_o  out  1  response valid
- resp_rdata_o  out  data_width_p  load data, zero-extended; 0 for stores
- resp_err_o  out  1  access error, meaningful when resp_valid_o = 1
- resp_yumi_i  in  1  core consumes response

## Operation
- States: IDLE, WAIT, RESP; state register, down-counter cnt_r (4 bits), captured wen/rdata/err.
- IDLE: req_yumi_o = req_valid_i & reset. On acceptance, go to WAIT with cnt_r = latency_p-1 if latency_p > 1, else go to RESP.
- Stores write size bytes at the accept edge. Loads sample memory at the accept edge, so a load sees all earlier accepted stores.
- WAIT: decrement cnt_r. At 0, go to RESP. req_yumi_o = 0.
- RESP: resp_valid_o = 1 and data/err held stable until resp_yumi_i. On resp_yumi_i, go to IDLE. A new request is not accepted in the same cycle.
- req_yumi_o = 0 in WAIT and RESP. req_* is ignored outside IDLE.
- Byte k of an access is at (req_addr_i + k) mod depth: addresses wrap at the top of memory.
- Illegal size (3 with data_width_p = 32): no write, rdata 0, resp_err_o = 1.
- Loads: bytes above the access size read 0.
- Memory contents are not reset. Contents are undefined until written.

## Timing
- Reset values: resp_valid_o 0, resp_rdata_o 0, resp_err_o 0, req_yumi_o 0, state IDLE, cnt_r 0.
- Reset mid-transaction aborts it. A store already accepted stays committed.
- Request accepted in cycle T: resp_valid_o first high in cycle T+latency_p.
- Minimum request spacing is latency_p+1 cycles, with resp_yumi_i asserted at the first valid cycle.
- resp_yumi_i is ignored when resp_valid_o = 0.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - An access whose address is not a multiple of its size is an error: no write, rdata 0, resp_err_o = 1.
  - Normal latency and handshake still apply.
- DMEM_ALIGN_CHECK_EN undefined:
  - Misaligned accesses complete normally, using byte-wise wrap addressing.
  - resp_err_o is raised only for illegal size.

## Test plan
- Reset held low 3 cycles with req_valid_i = 1 -> req_yumi_o = 0, resp_valid_o = 0, rdata = 0. Release -> req_yumi_o = 1 in the next cycle.
- latency_p = 3, word store 0xDEADBEEF @0x010 accepted T, then word load @0x010 -> store resp valid at T+3. Load returns 0xDEADBEEF. Byte load @0x012 returns 0x000000AD.
- Hold resp_yumi_i = 0 for 5 cycles in RESP -> resp_valid_o and rdata stable, req_yumi_o = 0 throughout. Yumi -> IDLE the next cycle.
- Word store 0x11223344 @0xFFE (addr_width_p = 12, check disabled) -> mem[0xFFE] = 0x44, mem[0xFFF] = 0x33, mem[0x000] = 0x22, mem[0x001] = 0x11.
- With DMEM_ALIGN_CHECK_EN, half store @0x003 -> resp_err_o = 1, memory unchanged. Size 3 at data_width_p = 32 -> resp_err_o = 1.
- data_width_p = 64, dword store 0x0123456789ABCDEF @0x008, then load -> same value, resp_err_o = 0.
